// File: rtl/spk_pkg.sv
// Shared definitions for the spike-processor input path: loader FSM encoding,
// default geometry of the packed input frame and the layer-select constants.
package spk_pkg;

    localparam int IN_W_DEF       = 8;
    localparam int CHUNK_W_DEF    = 128;
    localparam int NUM_CHUNKS_DEF = 8;

    localparam int MASK_W      = 3;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    typedef enum logic [1:0] {
        LAYER_INPUT  = 2'd0,
        LAYER_HIDDEN = 2'd1,
        LAYER_OUTPUT = 2'd2
    } layer_sel_e;

    function automatic int beats_per_chunk(input int chunk_w, input int in_w);
        return chunk_w / in_w;
    endfunction

endpackage

// File: rtl/spk_input_loader.sv
// Packs IN_W-wide spike beats LSB-first into CHUNK_W-wide chunks and writes
// NUM_CHUNKS of them per frame into the spike processor's input port.
module spk_input_loader
    import spk_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int CHUNK_W    = CHUNK_W_DEF,
    parameter int NUM_CHUNKS = NUM_CHUNKS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CHUNK_W-1:0]     spk_out,
    output logic                   spk_we,
    output logic [MASK_W-1:0]      spk_mask,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int BEATS  = beats_per_chunk(CHUNK_W, IN_W);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0]      BEAT_LAST  = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0]      BEAT_ONE   = BEAT_W'(1);
    localparam logic [MASK_W-1:0]      CHUNK_LAST = MASK_W'(NUM_CHUNKS - 1);
    localparam logic [MASK_W-1:0]      CHUNK_ONE  = MASK_W'(1);
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE    = FRAME_CNT_W'(1);

    ld_state_e              state_q, state_d;
    logic [BEAT_W-1:0]      beat_idx_q, beat_idx_d;
    logic [MASK_W-1:0]      chunk_idx_q, chunk_idx_d;
    logic [CHUNK_W-1:0]     pack_q, pack_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   ready_c;
    logic                   we_c;
    logic                   done_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            beat_idx_q  <= '0;
            chunk_idx_q <= '0;
            pack_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            chunk_idx_q <= chunk_idx_d;
            pack_q      <= pack_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // abort overrides every transition, including a start seen in IDLE
    always_comb begin
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        chunk_idx_d = chunk_idx_q;
        pack_d      = pack_q;
        frame_cnt_d = frame_cnt_q;
        ready_c     = 1'b0;
        we_c        = 1'b0;
        done_c      = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            beat_idx_d  = '0;
            chunk_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_FILL;
                        beat_idx_d  = '0;
                        chunk_idx_d = '0;
                    end
                end
                ST_FILL: begin
                    ready_c = 1'b1;
                    if (in_valid) begin
                        pack_d[int'(beat_idx_q)*IN_W +: IN_W] = in_data;
                        if (beat_idx_q == BEAT_LAST) begin
                            beat_idx_d = '0;
                            state_d    = ST_WRITE;
                        end else begin
                            beat_idx_d = beat_idx_q + BEAT_ONE;
                        end
                    end
                end
                ST_WRITE: begin
                    we_c = 1'b1;
                    if (chunk_idx_q == CHUNK_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        chunk_idx_d = chunk_idx_q + CHUNK_ONE;
                        state_d     = ST_FILL;
                    end
                end
                ST_DONE: begin
                    done_c      = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_ONE;
                    chunk_idx_d = '0;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are masked by reset in the same cycle so a reset landing on
    // WRITE or DONE never leaks a write or a completion downstream.
    assign in_ready   = ready_c & ~reset;
    assign spk_we     = we_c & ~reset;
    assign frame_done = done_c & ~reset;
    assign spk_out    = pack_q;
    assign spk_mask   = chunk_idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/spk_input_loader.md
SPK_INPUT_LOADER -- requirements
Module: spk_input_loader

Interface
REQ-001 Parameter: IN_W, 8, width of one input beat.
REQ-002 Parameter: CHUNK_W, 128, width of one write chunk; CHUNK_W/IN_W beats per chunk (16 at default).
REQ-003 Parameter: NUM_CHUNKS, 8, chunks per frame; frame = 1024 bits at default.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 start  input  1  single-cycle request to begin a frame load.
REQ-007 abort  input  1  synchronous cancel of the frame in progress.
REQ-008 in_data  input  IN_W  spike beat.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  loader accepts a beat this cycle.
REQ-011 spk_out  output  CHUNK_W  packed chunk; drives input_128n_spk_in of the spike processor.
REQ-012 spk_we  output  1  one-cycle chunk write strobe; drives input_128n_spk_in_we.
REQ-013 spk_mask  output  3  chunk index; drives input_128n_spk_in_mask.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_done  output  1  one-cycle pulse after the last chunk is written.
REQ-016 frame_cnt  output  8  completed-frame counter.

Function
REQ-017 States: IDLE, FILL, WRITE, DONE; encoded as one FSM.
REQ-018 IDLE: in_ready=0; start=1 -> FILL, beat_idx=0, chunk_idx=0.
REQ-019 FILL: in_ready=1; a beat is accepted when in_valid && in_ready.
REQ-020 Packing is LSB-first: beat k of a chunk goes to spk_out[k*IN_W+IN_W-1 : k*IN_W].
REQ-021 Accepting beat CHUNK_W/IN_W-1 -> WRITE on the next edge; beat_idx wraps to 0.
REQ-022 WRITE lasts exactly one cycle: spk_we=1, spk_mask=chunk_idx, in_ready=0, spk_out holds the complete chunk.
REQ-023 Latency: spk_we is asserted in the cycle immediately after the last beat's handshake.
REQ-024 After WRITE: if chunk_idx==NUM_CHUNKS-1 -> DONE, else chunk_idx+1 and -> FILL.
REQ-025 DONE lasts one cycle: frame_done=1, frame_cnt+1 (mod 256), then -> IDLE.
REQ-026 spk_we=0 and frame_done=0 in every other state.
REQ-027 A start outside IDLE is ignored and does not restart or queue a frame.
REQ-028 in_valid gaps in FILL stall packing; no partial chunk is ever written.
REQ-029 abort in any non-IDLE state -> IDLE next edge: beat_idx and chunk_idx cleared, no spk_we or frame_done, frame_cnt unchanged.
REQ-030 abort has priority over start, the handshake and all FSM transitions.
REQ-031 abort in the WRITE cycle still suppresses spk_we, because spk_we is decoded from the state and the cycle's abort.
REQ-032 Minimum frame duration at default parameters with continuous in_valid: 1 + 8*(16+1) + 1 = 138 cycles from start to frame_done, inclusive.

Reset
REQ-033 reset has priority over abort and start.
REQ-034 On reset: state=IDLE, beat_idx=0, chunk_idx=0, spk_out=0, spk_we=0, spk_mask=0, in_ready=0, busy=0, frame_done=0, frame_cnt=0.
REQ-035 reset asserted mid-frame discards all partial data; spk_we is not asserted in that cycle.

Structure
REQ-036 FSM state encoding and default IN_W/CHUNK_W/NUM_CHUNKS values live in a shared package, spk_pkg, alongside the layer-select constants.
REQ-037 Single module; no sub-module required.
REQ-038 The packing register is the only CHUNK_W-wide storage; no frame-wide (1024-bit) buffer is held.

Verification
REQ-039 reset, start, 128 beats of value 8'hA5 continuous -> 8 spk_we pulses, each with spk_out=128'hA5A5...A5, spk_mask 0..7 in order, one frame_done at cycle 138, frame_cnt=1.
REQ-040 Beats 0x00..0x0F for chunk 0 -> spk_out=128'h0F0E0D0C0B0A09080706050403020100, spk_mask=0.
REQ-041 in_valid toggling 1/0 every cycle -> same data as REQ-039, no partial writes, in_ready=1 throughout FILL.
REQ-042 abort after 40 beats -> exactly 2 spk_we pulses, no frame_done, busy=0 next cycle; following full frame writes masks 0..7.
REQ-043 start pulsed during FILL -> no effect on beat_idx or chunk_idx; 256 completed frames -> frame_cnt wraps to 0.
REQ-044 reset asserted in the WRITE cycle of chunk 3 -> spk_we=0 that cycle and all outputs at reset values the next cycle.
